// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine.
// Takes the effective address and store data from execute, checks alignment,
// drives a valid/ready data-memory bus with byte lanes and byte enables, and
// returns sign/zero-extended load data. The pipeline is stalled while a bus
// transaction is outstanding.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        align_fault,
  output logic        bus_error
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Timeout fires on the REQ cycle in which the counter would reach TIMEOUT_CYCLES,
  // giving exactly TIMEOUT_CYCLES cycles of dmem_req without ready.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns 1 when the access is an illegal width code or misaligned.
  function automatic logic access_fault(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (st) begin
      illegal = f3[2] | (f3[1:0] == 2'b11);
    end else begin
      illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

  // Selects the addressed lane of the read word and extends it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = rd;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  state_t           r_state;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [2:0]       r_func3;
  logic [1:0]       r_off;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_load_data;
  logic             r_done;
  logic             r_align_fault;
  logic             r_bus_error;

  logic             w_acc;
  logic             w_is_store;
  logic             w_fault;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  // Acceptance, fault detection and store lane/byte-enable generation.
  always_comb begin
    w_acc      = ex_valid & (mem_read | mem_write) & (r_state == S_IDLE);
    w_is_store = mem_write;
    w_fault    = access_fault(w_is_store, func3, addr[1:0]);
    w_be       = 4'b1111;
    w_wdata    = 32'd0;
    if (w_is_store) begin
      case (func3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end else begin
      w_be    = 4'b1111;
      w_wdata = 32'd0;
    end
  end

  // Transaction FSM with registered bus outputs and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_be          <= 4'd0;
      r_func3       <= 3'd0;
      r_off         <= 2'd0;
      r_cnt         <= '0;
      r_load_data   <= 32'd0;
      r_done        <= 1'b0;
      r_align_fault <= 1'b0;
      r_bus_error   <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_align_fault <= 1'b0;
      r_bus_error   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_fault) begin
              r_align_fault <= 1'b1;
            end else begin
              r_req   <= 1'b1;
              r_we    <= w_is_store;
              r_addr  <= {addr[31:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_func3 <= func3;
              r_off   <= addr[1:0];
              r_cnt   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            r_req       <= 1'b0;
            r_load_data <= r_we ? 32'd0 : extend_load(r_func3, r_off, dmem_rdata);
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_req       <= 1'b0;
            r_load_data <= 32'd0;
            r_bus_error <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall       = (w_acc & ~w_fault) | (r_state == S_REQ);
  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_be     = r_be;
  assign load_data   = r_load_data;
  assign done        = r_done;
  assign align_fault = r_align_fault;
  assign bus_error   = r_bus_error;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store engine. It consumes the execute-stage outputs: the ALU result is the effective address, and the selected op2 is the store data.
- Drives a valid/ready data-memory bus.
- Performs byte-lane alignment, byte enables and load sign/zero extension.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles dmem_req may wait for dmem_ready before bus_error (≥1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_valid  input  1  instruction in stage is valid
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
func3  input  3  RV32I load/store width code
addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value (op2_selected)
dmem_req  output  1  bus request valid
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ready  input  1  bus accepts/completes transfer this cycle
dmem_rdata  input  32  read word, valid when dmem_ready & !dmem_we
load_data  output  32  extended load result
done  output  1  one-cycle pulse: access complete, load_data valid
stall  output  1  hold upstream pipeline
align_fault  output  1  one-cycle pulse: misaligned or illegal func3
bus_error  output  1  one-cycle pulse: timeout

Behaviour:
- Reset (async, immediate): state=IDLE. All of the following are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_data, done, align_fault, bus_error, timeout counter.
- Reset mid-transaction drops dmem_req in the same cycle; no done is issued.
- States: IDLE, REQ, DONE.
- acc = ex_valid & (mem_read | mem_write) & state==IDLE.
- If mem_read and mem_write are both 1, the access is a store.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Fault condition: any other func3, a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
- IDLE, acc & fault: no bus request; align_fault=1 next cycle for one cycle; remain IDLE; stall=0.
- IDLE, acc & !fault: register dmem_addr, dmem_we, dmem_be, dmem_wdata, the extension type and the byte offset; go to REQ. dmem_req=1 from the next cycle.
- REQ: dmem_req and all bus outputs are held stable until dmem_ready is sampled high.
  - On dmem_ready: capture the extended load (loads) or 0 (stores) into load_data; go to DONE.
  - The counter increments each REQ cycle without ready. When the counter reaches TIMEOUT_CYCLES: drop dmem_req, load_data=0, bus_error=1 for the DONE cycle, go to DONE.
- DONE: done=1 for one cycle; dmem_req=0; return to IDLE; counter cleared. No new acceptance occurs in DONE.
- stall = acc & !fault (combinational) | state==REQ. stall=0 in DONE, so the pipeline advances on the done cycle.
- Minimum latency: accept cycle, then REQ with ready in the same cycle, then DONE = done 2 cycles after accept.
- Store lanes:
  - SB: wdata={4{store_data[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{store_data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata=store_data, be=4'b1111.
- Loads (lane selected by the registered offset; the read always uses be=4'b1111):
  - LB/LBU: byte = rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: half = rdata[16*off[1]+:16], sign- or zero-extended.
  - LW: rdata.
- dmem_ready outside REQ is ignored.
- load_data holds its value until the next completion or reset.

Test Plan:
- SW addr=0x100, store_data=0xDEADBEEF, dmem_ready after 2 wait cycles -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1. stall high for 4 cycles (accept + 3 REQ); done on the next cycle.
- LB addr=0x103, rdata=0x80123456, ready immediately -> be=1111, load_data=0xFFFFFF80, done 2 cycles after accept.
- LHU addr=0x102, rdata=0xABCD1234 -> load_data=0x0000ABCD. LH on the same inputs -> 0xFFFFABCD.
- SB addr=0x201, store_data=0x000000A5 -> dmem_addr=0x200, be=0010, wdata=0xA5A5A5A5.
- Fault cases, each giving one align_fault pulse, no dmem_req and stall=0:
  - SH addr=0x101.
  - LW addr=0x102.
  - func3=011.
- Timeout and reset:
  - LW with TIMEOUT_CYCLES=4 and dmem_ready held 0 -> req drops after 4 REQ cycles; bus_error and done pulse together; load_data=0.
  - Separately, assert rst during REQ -> dmem_req=0 immediately, no done.
